// File: rtl/spi_bus_arbiter.sv
// Two-master SPI pin arbiter: round-robin ownership with a guard gap between owners.
// Optional SPI_ARB_TIMEOUT_EN revokes ownership after TIMEOUT_CYCLES and flags it.
module spi_bus_arbiter #(
    parameter int unsigned GUARD_CYCLES   = 4,
    parameter logic        SCLK_IDLE      = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic io_systemClk,
    input  logic io_asyncResetn,
    input  logic a_sclk,
    input  logic a_ss,
    input  logic a_d0_we,
    input  logic a_d0_w,
    input  logic a_d1_we,
    input  logic a_d1_w,
    input  logic b_sclk,
    input  logic b_ss,
    input  logic b_d0_we,
    input  logic b_d0_w,
    input  logic b_d1_we,
    input  logic b_d1_w,
    output logic a_d0_r,
    output logic a_d1_r,
    output logic b_d0_r,
    output logic b_d1_r,
    output logic a_grant,
    output logic b_grant,
    output logic a_timeout,
    output logic b_timeout,
    output logic spi_sclk,
    output logic spi_ss,
    output logic spi_d0_we,
    output logic spi_d0_w,
    output logic spi_d1_we,
    output logic spi_d1_w,
    input  logic spi_d0_r,
    input  logic spi_d1_r
);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, GUARD} state_t;

    localparam int unsigned GW = $clog2(GUARD_CYCLES + 1);
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES - 1);
    // Pin bundle order: {ss, sclk, d0_we, d0_w, d1_we, d1_w}
    localparam logic [5:0] PINS_IDLE = {1'b1, SCLK_IDLE, 4'b0000};

    state_t          state_q, state_d;
    logic [GW-1:0]   guardCnt_q, guardCnt_d;
    logic            lastB_q, lastB_d;
    logic [5:0]      pins_q, pins_d;
    logic            reqA, reqB, toHitA, toHitB;

    wire [5:0] aPins = {a_ss, a_sclk, a_d0_we, a_d0_w, a_d1_we, a_d1_w};
    wire [5:0] bPins = {b_ss, b_sclk, b_d0_we, b_d0_w, b_d1_we, b_d1_w};

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] ownCnt_q, ownCnt_d;
    logic          ineligA_q, ineligA_d, ineligB_q, ineligB_d;
    logic          aTimeout_q, aTimeout_d, bTimeout_q, bTimeout_d;

    assign toHitA     = (state_q == OWN_A) && !a_ss && (ownCnt_q == TO_LAST);
    assign toHitB     = (state_q == OWN_B) && !b_ss && (ownCnt_q == TO_LAST);
    assign ownCnt_d   = (state_q == OWN_A || state_q == OWN_B) ? ownCnt_q + TW'(1) : '0;
    // A revoked master stays out until it lets its ss go high, so it cannot resume mid-frame.
    assign ineligA_d  = toHitA | (ineligA_q & ~a_ss);
    assign ineligB_d  = toHitB | (ineligB_q & ~b_ss);
    assign aTimeout_d = aTimeout_q | toHitA;
    assign bTimeout_d = bTimeout_q | toHitB;
    assign reqA       = ~a_ss & ~ineligA_q;
    assign reqB       = ~b_ss & ~ineligB_q;
    assign a_timeout  = aTimeout_q;
    assign b_timeout  = bTimeout_q;

    always_ff @(posedge io_systemClk) begin
        if (!io_asyncResetn) begin
            ownCnt_q   <= '0;
            ineligA_q  <= 1'b0;
            ineligB_q  <= 1'b0;
            aTimeout_q <= 1'b0;
            bTimeout_q <= 1'b0;
        end else begin
            ownCnt_q   <= ownCnt_d;
            ineligA_q  <= ineligA_d;
            ineligB_q  <= ineligB_d;
            aTimeout_q <= aTimeout_d;
            bTimeout_q <= bTimeout_d;
        end
    end
`else
    logic [31:0] unusedTimeoutCycles;
    assign unusedTimeoutCycles = TIMEOUT_CYCLES;
    assign toHitA    = 1'b0;
    assign toHitB    = 1'b0;
    assign reqA      = ~a_ss;
    assign reqB      = ~b_ss;
    assign a_timeout = 1'b0;
    assign b_timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        guardCnt_d = guardCnt_q;
        lastB_d    = lastB_q;
        pins_d     = PINS_IDLE;
        case (state_q)
            IDLE: begin
                // On a tie the master that did not own the bus last wins.
                if (reqA && (!reqB || lastB_q)) begin
                    state_d = OWN_A;
                    lastB_d = 1'b0;
                end else if (reqB) begin
                    state_d = OWN_B;
                    lastB_d = 1'b1;
                end
            end
            OWN_A: begin
                if (a_ss || toHitA) begin
                    state_d    = GUARD;
                    guardCnt_d = GUARD_LOAD;
                end else begin
                    pins_d = aPins;
                end
            end
            OWN_B: begin
                if (b_ss || toHitB) begin
                    state_d    = GUARD;
                    guardCnt_d = GUARD_LOAD;
                end else begin
                    pins_d = bPins;
                end
            end
            GUARD: begin
                if (guardCnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    guardCnt_d = guardCnt_q - GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge io_systemClk) begin
        if (!io_asyncResetn) begin
            state_q    <= IDLE;
            guardCnt_q <= '0;
            lastB_q    <= 1'b1;
            pins_q     <= PINS_IDLE;
        end else begin
            state_q    <= state_d;
            guardCnt_q <= guardCnt_d;
            lastB_q    <= lastB_d;
            pins_q     <= pins_d;
        end
    end

    assign {spi_ss, spi_sclk, spi_d0_we, spi_d0_w, spi_d1_we, spi_d1_w} = pins_q;

    assign a_grant = (state_q == OWN_A);
    assign b_grant = (state_q == OWN_B);
    assign a_d0_r  = a_grant & spi_d0_r;
    assign a_d1_r  = a_grant & spi_d1_r;
    assign b_d0_r  = b_grant & spi_d0_r;
    assign b_d1_r  = b_grant & spi_d1_r;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed self-checking bench for spi_bus_arbiter in its default build
// (SPI_ARB_TIMEOUT_EN undefined, GUARD_CYCLES=4, SCLK_IDLE=0).
module tb_spi_bus_arbiter;

   logic clock = 1'b0;
   logic resetn;
   logic aSclk, aSs, aD0We, aD0W, aD1We, aD1W;
   logic bSclk, bSs, bD0We, bD0W, bD1We, bD1W;
   logic aD0R, aD1R, bD0R, bD1R, aGrant, bGrant, aTimeout, bTimeout;
   logic spiSclk, spiSs, spiD0We, spiD0W, spiD1We, spiD1W;
   logic spiD0R, spiD1R;

   int checkCount = 0;
   int errorCount = 0;

   always #5 clock = ~clock;

   spi_bus_arbiter dut (
      .io_systemClk  (clock),
      .io_asyncResetn(resetn),
      .a_sclk        (aSclk),
      .a_ss          (aSs),
      .a_d0_we       (aD0We),
      .a_d0_w        (aD0W),
      .a_d1_we       (aD1We),
      .a_d1_w        (aD1W),
      .b_sclk        (bSclk),
      .b_ss          (bSs),
      .b_d0_we       (bD0We),
      .b_d0_w        (bD0W),
      .b_d1_we       (bD1We),
      .b_d1_w        (bD1W),
      .a_d0_r        (aD0R),
      .a_d1_r        (aD1R),
      .b_d0_r        (bD0R),
      .b_d1_r        (bD1R),
      .a_grant       (aGrant),
      .b_grant       (bGrant),
      .a_timeout     (aTimeout),
      .b_timeout     (bTimeout),
      .spi_sclk      (spiSclk),
      .spi_ss        (spiSs),
      .spi_d0_we     (spiD0We),
      .spi_d0_w      (spiD0W),
      .spi_d1_we     (spiD1We),
      .spi_d1_w      (spiD1W),
      .spi_d0_r      (spiD0R),
      .spi_d1_r      (spiD1R)
   );

   // Counts one comparison and reports it when observed and expected differ.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Drives the request and clock lines of both masters.
   task automatic applyStimulus(input logic aSsV, input logic aSclkV, input logic bSsV, input logic bSclkV);
      aSs   = aSsV;
      aSclk = aSclkV;
      bSs   = bSsV;
      bSclk = bSclkV;
   endtask

   // Advances one rising edge and settles 1 time unit past it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Walks the 4 guard cycles after a release edge, then the grant edge.
   task automatic guardThenGrant(input string tag, input logic expA, input logic expB);
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput({tag, "_guardSs"}, spiSs, 1'b1);
         checkOutput({tag, "_guardNoGrant"}, {aGrant, bGrant}, 2'b00);
      end
      tick();
      checkOutput({tag, "_grant"}, {aGrant, bGrant}, {expA, expB});
   endtask

   initial begin
      resetn = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      {aD0We, aD0W, aD1We, aD1W} = 4'b0;
      {bD0We, bD0W, bD1We, bD1W} = 4'b0;
      {spiD0R, spiD1R} = 2'b00;
      tick();
      tick();
      resetn = 1'b1;
      checkOutput("rstSs", spiSs, 1'b1);
      checkOutput("rstSclk", spiSclk, 1'b0);
      checkOutput("rstWe", {spiD0We, spiD0W, spiD1We, spiD1W}, 4'b0000);
      checkOutput("rstGrant", {aGrant, bGrant}, 2'b00);
      checkOutput("rstTimeout", {aTimeout, bTimeout}, 2'b00);

      // A alone requests: grant after one edge, pins follow one edge later.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      aD0We = 1'b1;
      aD0W  = 1'b1;
      tick();
      checkOutput("aGrantEarly", {aGrant, bGrant}, 2'b10);
      checkOutput("aPinsNotYet", {spiSs, spiD0We}, 2'b10);
      tick();
      checkOutput("aPinsSs", spiSs, 1'b0);
      checkOutput("aPinsD0", {spiD0We, spiD0W}, 2'b11);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      #1;
      checkOutput("aSclkLatency", spiSclk, 1'b0);
      tick();
      checkOutput("aSclkFwd", spiSclk, 1'b1);
      spiD1R = 1'b1;
      #1;
      checkOutput("readOwnerA", {aD1R, bD1R}, 2'b10);
      checkOutput("readD0Zero", {aD0R, bD0R}, 2'b00);

      // Reset while A still owns with ss low.
      resetn = 1'b0;
      tick();
      checkOutput("midRstSs", spiSs, 1'b1);
      checkOutput("midRstGrant", aGrant, 1'b0);
      checkOutput("midRstSclk", spiSclk, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      {aD0We, aD0W, spiD1R} = 3'b000;
      tick();
      resetn = 1'b1;

      // Simultaneous requests from reset: A first, then B after the guard.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("tieGrantA", {aGrant, bGrant}, 2'b10);
      tick();
      checkOutput("tiePinsA", spiSs, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("tieRelease", {aGrant, spiSs}, 2'b01);
      guardThenGrant("tieB", 1'b0, 1'b1);
      checkOutput("tieBPinsNotYet", spiSs, 1'b1);
      tick();
      checkOutput("tieBPins", spiSs, 1'b0);

      // B owns; A waits, then grants alternate A, B, A.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("bSclkFwd", spiSclk, 1'b1);
      checkOutput("aWaitsForB", aGrant, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      checkOutput("bRelease", bGrant, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      guardThenGrant("rrA1", 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("bSclkIgnored", {spiSs, spiSclk}, 2'b00);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("aSclkOwner", spiSclk, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("aRelease", aGrant, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      guardThenGrant("rrB", 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      checkOutput("bRelease2", bGrant, 1'b0);
      guardThenGrant("rrA2", 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      checkOutput("finalIdleGrant", {aGrant, bGrant}, 2'b00);
      checkOutput("finalTimeout", {aTimeout, bTimeout}, 2'b00);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
